ptr_list_sink: RTL and testbench
================================

PTR_LIST_SINK -- requirements
Module: ptr_list_sink

Interface
REQ-001 Parameter DEPTH, default 16, number of linked-list nodes (power of two, 4..256).
REQ-002 Parameter W_PTR, default 8, width of a Pointer value (8 for n=256).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_ptr  input  W_PTR  incoming Pointer value from the pointer request generator.
REQ-006 in_ptr_vld  input  1  in_ptr is valid this cycle.
REQ-007 in_ptr_rdy  output  1  block accepts in_ptr this cycle; push occurs iff in_ptr_vld && in_ptr_rdy.
REQ-008 pop  input  1  request to remove the oldest stored Pointer.
REQ-009 out_ptr  output  W_PTR  popped Pointer value, registered.
REQ-010 out_ptr_vld  output  1  one-cycle pulse qualifying out_ptr.
REQ-011 count  output  $clog2(DEPTH+1)  number of stored Pointers, registered.
REQ-012 empty, full  output  1 each  count==0 / count==DEPTH, derived from registered count.

Function
REQ-013 Storage: node arrays data[DEPTH] (W_PTR) and next[DEPTH] ($clog2(DEPTH)); registers head, tail, free_head, count; FIFO order kept as a singly linked list, unused nodes as a free list.
REQ-014 FSM states INIT and RUN; rst forces INIT with init index 0.
REQ-015 INIT: one node per cycle, next[i] = i+1 (wrapping to 0 at DEPTH-1); after DEPTH cycles -> RUN with free_head=0, count=0.
REQ-016 in_ptr_rdy = (state==RUN) && !full; pop is ignored in INIT or when empty.
REQ-017 Push: node = free_head; data[node]=in_ptr; free_head=next[node]; if count==0 head=node else next[tail]=node; tail=node; count+1.
REQ-018 Pop accepted (RUN, !empty): out_ptr <= data[head], out_ptr_vld=1 next cycle (latency 1); next[head]=free_head; free_head=head; head=next[head]; count-1.
REQ-019 Simultaneous push and pop, count>=2: both applied; count unchanged; push takes pre-pop free_head, popped node becomes new free_head, its next pointing at post-push free list head.
REQ-020 Simultaneous push and pop, count==1: popped value is old head; head=tail=pushed node; count stays 1.
REQ-021 Push while empty with pop asserted: pop ignored, push applied; no same-cycle bypass to out_ptr.
REQ-022 Full: in_ptr_rdy=0; pop still accepted, in_ptr_rdy rises the following cycle.
REQ-023 Pointer values are opaque; any W_PTR value including 0 and all-ones is stored unchanged.
REQ-024 out_ptr holds its last value when out_ptr_vld=0.

Reset
REQ-025 rst=1 at any posedge, including mid-operation: state=INIT, count=0, out_ptr_vld=0, out_ptr=0, in_ptr_rdy=0, head=tail=free_head=0; stored contents discarded.
REQ-026 rst released: in_ptr_rdy rises exactly DEPTH cycles after the first cycle with rst=0.
REQ-027 data[] need not be cleared by reset.

Verification
REQ-028 Reset 2 cycles, release -> in_ptr_rdy=0 for 16 cycles, then 1; count=0, empty=1, out_ptr_vld never asserted.
REQ-029 Push 3,7,255 on consecutive cycles, then pop 3 cycles -> out_ptr_vld pulses with 3,7,255 one cycle after each pop; count 3 -> 0.
REQ-030 Push 16 values 0..15 -> full=1, in_ptr_rdy=0, 17th in_ptr_vld ignored; one pop -> out_ptr=0, in_ptr_rdy=1 next cycle.
REQ-031 count==1 holding 5, push 9 with pop same cycle -> out_ptr=5, count=1; next pop -> out_ptr=9, empty=1.
REQ-032 Drive 200 cycles of random push/pop against a reference queue -> every popped value matches, count matches, no lost or duplicated node (free list + list length == 16).
REQ-033 Assert rst with count=6 -> next cycle count=0, out_ptr_vld=0, INIT repeated; later push/pop of 42 returns 42.

Source files
------------

// File: rtl/ptr_list_sink_if.sv
// Pointer sink bus: push side (in_ptr/vld/rdy), pop request, and the
// registered pop result plus occupancy status.
interface ptr_list_sink_if #(
  parameter int DEPTH = 16,
  parameter int W_PTR = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W_PTR-1:0] in_ptr;
  logic             in_ptr_vld;
  logic             in_ptr_rdy;
  logic             pop;
  logic [W_PTR-1:0] out_ptr;
  logic             out_ptr_vld;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;

  modport master (
    output in_ptr, in_ptr_vld, pop,
    input  in_ptr_rdy, out_ptr, out_ptr_vld, count, empty, full
  );

  modport slave (
    input  in_ptr, in_ptr_vld, pop,
    output in_ptr_rdy, out_ptr, out_ptr_vld, count, empty, full
  );
endinterface

// File: rtl/ptr_list_sink.sv
// FIFO of opaque pointer values kept as a singly linked list over a node pool;
// unused nodes form a free list that INIT threads once after every reset.
module ptr_list_sink #(
  parameter int DEPTH = 16,
  parameter int W_PTR = 8
) (
  input  logic           clk,
  input  logic           rst,
  ptr_list_sink_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [AW-1:0] LAST_NODE  = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE        = CW'(1);

  logic [W_PTR-1:0] node_data [DEPTH];
  logic [AW-1:0]    node_next [DEPTH];

  logic [0:0]       state;
  logic [AW-1:0]    init_idx;
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic [AW-1:0]    free_head;
  logic [CW-1:0]    count;
  logic [W_PTR-1:0] out_ptr;
  logic             out_ptr_vld;

  logic             empty;
  logic             full;
  logic             rdy;
  logic             do_push;
  logic             do_pop;
  logic             link_tail;
  logic             restart_list;
  logic [AW-1:0]    free_after_push;
  logic [AW-1:0]    head_nxt;
  logic [AW-1:0]    tail_nxt;
  logic [AW-1:0]    free_head_nxt;
  logic [CW-1:0]    count_nxt;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign rdy     = (state == ST_RUN) && !full;
  assign do_push = bus.in_ptr_vld && rdy;
  assign do_pop  = bus.pop && (state == ST_RUN) && !empty;

  // The pushed node starts a fresh list when the list is empty or its only
  // node is leaving this same cycle; otherwise it is appended after tail.
  assign restart_list    = do_push && (empty || (do_pop && count == ONE));
  assign link_tail       = do_push && !restart_list;
  assign free_after_push = do_push ? node_next[free_head] : free_head;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    head_nxt      = head;
    tail_nxt      = tail;
    free_head_nxt = free_head;
    count_nxt     = count;
    if (do_push) begin
      tail_nxt      = free_head;
      free_head_nxt = node_next[free_head];
    end
    if (do_pop) begin
      free_head_nxt = head;
      head_nxt      = node_next[head];
    end
    if (restart_list) head_nxt = free_head;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + ONE;
      2'b01:   count_nxt = count - ONE;
      default: count_nxt = count;
    endcase
  end

  // NOTE: the node pool has no reset; INIT rewrites every link and data is only read after a push wrote it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_INIT) begin
        node_next[init_idx] <= init_idx + AW'(1);
      end else begin
        if (do_push)   node_data[free_head] <= bus.in_ptr;
        if (link_tail) node_next[tail]      <= free_head;
        // Popped node rejoins the free list ahead of whatever the push left.
        if (do_pop)    node_next[head]      <= free_after_push;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_INIT;
      init_idx    <= '0;
      head        <= '0;
      tail        <= '0;
      free_head   <= '0;
      count       <= '0;
      out_ptr     <= '0;
      out_ptr_vld <= 1'b0;
    end else begin
      out_ptr_vld <= 1'b0;
      if (state == ST_INIT) begin
        init_idx <= init_idx + AW'(1);
        if (init_idx == LAST_NODE) begin
          state     <= ST_RUN;
          free_head <= '0;
          count     <= '0;
        end
      end else begin
        head      <= head_nxt;
        tail      <= tail_nxt;
        free_head <= free_head_nxt;
        count     <= count_nxt;
        if (do_pop) begin
          out_ptr     <= node_data[head];
          out_ptr_vld <= 1'b1;
        end
      end
    end
  end

  assign bus.in_ptr_rdy  = rdy;
  assign bus.out_ptr     = out_ptr;
  assign bus.out_ptr_vld = out_ptr_vld;
  assign bus.count       = count;
  assign bus.empty       = empty;
  assign bus.full        = full;
endmodule

// File: tb/tb_ptr_list_sink.sv
// Bench for ptr_list_sink: directed vector table, hand sequences for full and
// reset corners, and random traffic against a queue-based reference model.
module tb_ptr_list_sink;
  localparam int DEPTH = 16;
  localparam int W     = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ptr_list_sink_if #(.DEPTH(DEPTH), .W_PTR(W)) bus ();

  ptr_list_sink #(.DEPTH(DEPTH), .W_PTR(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int passes = 0;

  // Reference model: stored pointers in arrival order, init cycles left,
  // and the last value the output should be holding.
  logic [W-1:0] q[$];
  int           init_left;
  logic [W-1:0] last_out;

  typedef struct {
    logic         vld;
    logic [W-1:0] ptr;
    logic         pop;
    logic         exp_rdy;
    logic         exp_vld;
    logic [W-1:0] exp_out;
    int           exp_count;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // One clock of stimulus; the model decides acceptance from the pre-edge
  // occupancy, so a pop on an empty queue is ignored even if a push lands.
  task automatic cycle(input logic vld, input logic [W-1:0] ptr, input logic p);
    logic         model_rdy;
    logic         acc_push;
    logic         acc_pop;
    logic [W-1:0] exp_val;
    bus.in_ptr_vld = vld;
    bus.in_ptr     = ptr;
    bus.pop        = p;
    model_rdy = (init_left == 0) && (q.size() < DEPTH);
    check("in_ptr_rdy", 32'(bus.in_ptr_rdy), 32'(model_rdy));
    acc_pop  = p && (init_left == 0) && (q.size() > 0);
    acc_push = vld && model_rdy;
    exp_val  = last_out;
    if (acc_pop) exp_val = q.pop_front();
    if (acc_push) q.push_back(ptr);
    @(posedge clk);
    #1;
    if (init_left > 0) init_left--;
    check("out_ptr_vld", 32'(bus.out_ptr_vld), 32'(acc_pop));
    check("out_ptr", 32'(bus.out_ptr), 32'(exp_val));
    last_out = exp_val;
    check("count", 32'(bus.count), 32'(q.size()));
    check("empty", 32'(bus.empty), 32'(q.size() == 0));
    check("full", 32'(bus.full), 32'(q.size() == DEPTH));
  endtask

  task automatic do_reset(input int n);
    rst            = 1'b1;
    bus.in_ptr_vld = 1'b0;
    bus.in_ptr     = '0;
    bus.pop        = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
      check("rst_rdy", 32'(bus.in_ptr_rdy), 32'd0);
      check("rst_vld", 32'(bus.out_ptr_vld), 32'd0);
      check("rst_out", 32'(bus.out_ptr), 32'd0);
      check("rst_count", 32'(bus.count), 32'd0);
      check("rst_empty", 32'(bus.empty), 32'd1);
    end
    rst       = 1'b0;
    bus.pop   = 1'b0;
    q.delete();
    init_left = DEPTH;
    last_out  = '0;
  endtask

  initial begin
    bus.in_ptr_vld = 1'b0;
    bus.in_ptr     = '0;
    bus.pop        = 1'b0;
    init_left      = DEPTH;
    last_out       = '0;

    vecs[0] = '{1'b1, 8'd3,   1'b0, 1'b1, 1'b0, 8'd0,   1};
    vecs[1] = '{1'b1, 8'd7,   1'b0, 1'b1, 1'b0, 8'd0,   2};
    vecs[2] = '{1'b1, 8'd255, 1'b0, 1'b1, 1'b0, 8'd0,   3};
    vecs[3] = '{1'b0, 8'd0,   1'b1, 1'b1, 1'b1, 8'd3,   2};
    vecs[4] = '{1'b0, 8'd0,   1'b1, 1'b1, 1'b1, 8'd7,   1};
    vecs[5] = '{1'b0, 8'd0,   1'b1, 1'b1, 1'b1, 8'd255, 0};
    vecs[6] = '{1'b0, 8'd0,   1'b1, 1'b1, 1'b0, 8'd255, 0};
    vecs[7] = '{1'b1, 8'd5,   1'b1, 1'b1, 1'b0, 8'd255, 1};
    vecs[8] = '{1'b1, 8'd9,   1'b1, 1'b1, 1'b1, 8'd5,   1};
    vecs[9] = '{1'b0, 8'd0,   1'b1, 1'b1, 1'b1, 8'd9,   0};

    // Reset, then the ready flag must stay low for exactly DEPTH cycles.
    do_reset(2);
    repeat (DEPTH) cycle(1'b0, '0, 1'b1);
    check("rdy_after_init", 32'(bus.in_ptr_rdy), 32'd1);

    // Directed table: ordered pops, pop on empty, push+pop corners.
    for (int i = 0; i < 10; i++) begin
      check("vec_rdy", 32'(bus.in_ptr_rdy), 32'(vecs[i].exp_rdy));
      cycle(vecs[i].vld, vecs[i].ptr, vecs[i].pop);
      check("vec_vld", 32'(bus.out_ptr_vld), 32'(vecs[i].exp_vld));
      check("vec_out", 32'(bus.out_ptr), 32'(vecs[i].exp_out));
      check("vec_count", 32'(bus.count), 32'(vecs[i].exp_count));
    end

    // Fill to capacity, offer one more, then a single pop reopens the input.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, W'(i), 1'b0);
    check("full_flag", 32'(bus.full), 32'd1);
    check("full_rdy", 32'(bus.in_ptr_rdy), 32'd0);
    cycle(1'b1, 8'd99, 1'b0);
    check("full_count", 32'(bus.count), 32'(DEPTH));
    cycle(1'b0, '0, 1'b1);
    check("full_pop_out", 32'(bus.out_ptr), 32'd0);
    check("full_pop_rdy", 32'(bus.in_ptr_rdy), 32'd1);
    repeat (DEPTH) cycle(1'b0, '0, 1'b1);
    check("drained", 32'(bus.empty), 32'd1);

    // Random traffic, biased so the queue wanders between empty and full.
    for (int i = 0; i < 200; i++) begin
      logic [W-1:0] v;
      v = W'($urandom);
      if ($urandom_range(0, 9) == 0) v = '0;
      if ($urandom_range(0, 9) == 0) v = '1;
      cycle($urandom_range(0, 99) < 60, v, $urandom_range(0, 99) < 45);
    end

    // Every node must still be reachable: refill to exactly DEPTH, then drain.
    repeat (DEPTH + 2) cycle(1'b1, W'($urandom), 1'b0);
    check("refill_count", 32'(bus.count), 32'(DEPTH));
    repeat (DEPTH + 1) cycle(1'b0, '0, 1'b1);
    check("redrain_empty", 32'(bus.empty), 32'd1);

    // Reset mid-operation with six entries stored.
    for (int i = 0; i < 6; i++) cycle(1'b1, W'(i + 20), 1'b0);
    check("pre_rst_count", 32'(bus.count), 32'd6);
    do_reset(1);
    repeat (DEPTH) cycle(1'b1, 8'd77, 1'b1);
    cycle(1'b1, 8'd42, 1'b0);
    cycle(1'b0, '0, 1'b1);
    check("post_rst_out", 32'(bus.out_ptr), 32'd42);
    check("post_rst_vld", 32'(bus.out_ptr_vld), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
